uart_rx_fifo: RTL

- Synthesizable serial receiver for the SoC's UART TX line (8N1, LSB first, idle high), with an output FIFO.
- Sits directly downstream of the SoC's ser_tx. Used on-chip as a loopback/monitor sink, and as the self-checking receive stage in SoC benches.
- Samples mid-bit using a half-period counter. Pushes good bytes into a small FIFO. Flags framing and overrun errors.

---
 rtl/uart_rx_fifo_pkg.sv | 25 ++
 rtl/uart_rx_fifo_fifo.sv | 109 ++++++++++
 rtl/uart_rx_fifo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the UART receive path: receiver state encoding and
// bit-period helpers derived from the half-bit timing parameter.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4
  } rx_state_e;

  localparam int DEFAULT_HALF_PERIOD = 53;
  localparam int BIT_PERIOD          = 2 * DEFAULT_HALF_PERIOD;

  // Full bit time in clk cycles for a given half-bit time.
  function automatic int bit_period(input int half_period);
    return 2 * half_period;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with a registered head word.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on empty is ignored.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   push         write request, push_data is the word to write
//   pop          read request (acts only when the FIFO is non-empty)
//   head_data    registered word at the FIFO head
//   valid        registered: FIFO non-empty
//   full         registered: FIFO holds DEPTH words
//   count        registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             valid_r;
  logic             full_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (count_r != CW'(0));
  assign push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);

  // Next occupancy, next read pointer and next head word.
  always_comb begin
    count_nxt_s  = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = head_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The word being written this cycle becomes the head when it lands in
    // the slot the read pointer moves to (empty FIFO, or last word popped).
    if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage write; contents need no reset because valid gates their use.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered status/head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      head_r   <= WIDTH'(0);
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (count_nxt_s != CW'(0));
      full_r   <= (count_nxt_s == CW'(DEPTH));
    end
  end

  assign head_data = head_r;
  assign valid     = valid_r;
  assign full      = full_r;
  assign count     = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 serial receiver (LSB first, idle high) with an output FIFO. The line is
// synchronised by two flops, the start bit is validated at its midpoint and
// each following bit is sampled one full bit later. Good bytes are pushed
// into the FIFO; framing and overrun errors are reported as one-cycle pulses.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   ser_in      asynchronous serial line, idle high
//   out_data    byte at FIFO head (registered)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts head when out_valid && out_ready
//   fifo_count  current FIFO occupancy
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped because FIFO full
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int HALF_PERIOD = 53,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int BIT_CYCLES = bit_period(HALF_PERIOD);
  localparam int CNT_W      = $clog2(BIT_CYCLES);

  logic             sync1_r;
  logic             rx_r;
  rx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shreg_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             half_done_s;
  logic             bit_done_s;
  logic             push_s;
  logic             fifo_full_s;
  logic             fifo_valid_s;

  assign half_done_s = (cnt_r == CNT_W'(HALF_PERIOD - 1));
  assign bit_done_s  = (cnt_r == CNT_W'(BIT_CYCLES - 1));
  // A good byte is handed to the FIFO on the stop-bit sample cycle.
  assign push_s      = (state_r == ST_STOP) && bit_done_s && rx_r;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rx_r    <= 1'b1;
    end else begin
      sync1_r <= ser_in;
      rx_r    <= sync1_r;
    end
  end

  // Receive state machine: start validation, data sampling, stop check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_WAIT_IDLE;
      cnt_r       <= CNT_W'(0);
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'd0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        // Only leave once the line is seen high, so a frame already in
        // progress is never picked up mid-byte.
        ST_WAIT_IDLE: begin
          cnt_r <= CNT_W'(0);
          if (rx_r) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          cnt_r <= CNT_W'(0);
          if (!rx_r) begin
            state_r <= ST_START;
          end
        end
        // A line that is high again at mid start bit was a glitch.
        ST_START: begin
          if (half_done_s) begin
            cnt_r     <= CNT_W'(0);
            bit_idx_r <= 3'd0;
            if (rx_r) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            cnt_r   <= CNT_W'(0);
            shreg_r <= {rx_r, shreg_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        // Returning to IDLE on the sample cycle lets a start bit that
        // follows the stop bit directly be caught.
        ST_STOP: begin
          if (bit_done_s) begin
            cnt_r <= CNT_W'(0);
            if (rx_r) begin
              state_r <= ST_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_WAIT_IDLE;
          cnt_r   <= CNT_W'(0);
        end
      endcase
    end
  end

  // Overrun: a good byte arrived while full and nothing left the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= push_s && fifo_full_s && !(fifo_valid_s && out_ready);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (shreg_r),
    .pop       (out_ready),
    .head_data (out_data),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s),
    .count     (fifo_count)
  );

  assign out_valid = fifo_valid_s;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule
